sme_scan_ctrl: RTL and testbench
================================

Name: sme_scan_ctrl

Overview:
- Sequencer for the string-match engine: once string and pattern buffers are loaded, scans start positions and drives buffer read addresses, one character comparison per cycle.
- Produces match and match_index for the output stage.
- Sits between the string/pattern capture registers and the valid/match output logic; the buffers themselves are external, with combinational reads.

Parameters:
- CHAR_W, 8, character width in bits.
- STR_DEPTH, 32, maximum string length; str_addr width is 5.
- PAT_DEPTH, 8, maximum pattern length; pat_addr width is 3.
- SPACE_CH, 8'h20, word separator used by the anchors.
- HEAD_CH, 8'h5E, '^' start anchor.
- TAIL_CH, 8'h24, '$' end anchor.
- ANY_CH, 8'h2E, '.' single-character wildcard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- str_len  in  6  valid string length, 1..32, held stable while busy.
- pat_len  in  4  valid pattern length, 1..8, held stable while busy.
- str_addr  out  5  string buffer read address.
- str_char  in  8  str[str_addr], same-cycle combinational read.
- pat_addr  out  3  pattern buffer read address.
- pat_char  in  8  pat[pat_addr], same-cycle combinational read.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- match  out  1  1 = pattern found; held until the next accepted start.
- match_index  out  5  start index of the first (lowest) match, 0 when no match; held.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy=0, done=0, match=0, match_index=0, str_addr=0, pat_addr=0.
  - Asserting reset mid-scan aborts the scan; no done pulse is issued.
- Anchors:
  - '^' is an anchor only at pat[0]; '$' is an anchor only at pat[pat_len-1].
  - Anywhere else they are literal characters.
  - Both anchors are zero-width.
  - pat_len=1 with pat[0]='^' is a head anchor only.
  - Body length L = pat_len - has_head - has_tail; L may be 0.
  - Body char j is read at pat_addr = j + has_head.
- '^' condition: s==0 or str[s-1]==SPACE_CH.
- '$' condition: s+L==str_len or str[s+L]==SPACE_CH.
- Character equality: exact 8-bit compare, except pattern '.' matches any character, including space.
- States:
  - IDLE: start=1 -> HEAD; clears match and match_index at that same edge. start while busy is ignored.
  - HEAD: pat_addr=0; latch has_head. -> TAIL.
  - TAIL: pat_addr=pat_len-1; latch has_tail.
    - If L > str_len -> DONE with no match.
    - Else s=0, j=0 -> PRE if has_head, else BODY (or POST if L==0, or DONE-match if L==0 and no tail).
  - PRE: str_addr=s-1 (0 when s==0; the read is ignored).
    - Fail -> next start.
    - Pass -> BODY, or POST if L==0, or DONE-match if L==0 and no tail.
  - BODY: str_addr=s+j, pat_addr=j+has_head.
    - Mismatch -> next start.
    - Match with j<L-1 -> j+1.
    - Match with j==L-1 -> POST if has_tail, else DONE-match.
  - POST: str_addr=s+L; always one cycle, even when s+L==str_len (read ignored in that case).
    - Pass -> DONE-match; fail -> next start.
  - Next start: s+1, j=0.
    - If s+1 > str_len-L -> DONE with no match.
    - Else -> PRE if has_head, else BODY/POST per L.
  - DONE: done=1 for exactly one cycle; match and match_index are registered on entry to DONE. -> IDLE.
- DONE-match sets match=1 and match_index=s. No-match sets match=0 and match_index=0.
- Arithmetic:
  - s and s+L use 6-bit unsigned arithmetic.
  - str_addr is the low 5 bits; no out-of-range read is ever issued for a valid s.
  - Worst-case latency is bounded by 3 + 33*(L+2) cycles.

Optional Feature:
- Macro: SME_CASE_FOLD_EN.
- Defined: body compare is case-insensitive for ASCII letters; 0x41-0x5A and 0x61-0x7A are folded before compare. Anchors, wildcard and space are unaffected.
- Undefined: exact 8-bit compare only.

Test Plan:
- str "ab" (len 2), pat "b" (len 1), pulse start -> done high at the 5th rising edge after start is sampled, match=1, match_index=1.
- str "the cat", pat "^cat" -> match=1, match_index=4. Same string with pat "^at" -> match=0, match_index=0.
- str "cats cat", pat "cat$" -> the s=0 POST check fails on 's'; s=5 passes at end of string -> match=1, match_index=5.
- str "abc", pat "a.c" -> match=1, index 0. Pat "abcd" (L > str_len) -> done two cycles after HEAD, match=0.
- pat "^$" (L=0), str "x y" -> no position satisfies both anchors -> match=0. Pat "^" -> match=1, index 0.
- Reset asserted during BODY of a long scan -> outputs zero immediately and no done pulse. Next start runs normally. start held high during busy has no effect.

Source files
------------

// File: rtl/sme_scan_ctrl.sv
// sme_scan_ctrl - scan sequencer for the string-match engine.
// Steps through the start positions of a loaded string. Each cycle it drives
// read addresses into the external string/pattern buffers (combinational
// reads) and compares one character. The result goes to the output stage.
//   clk, reset (async, active-high)
//   start              : request a scan, sampled only in IDLE
//   str_len, pat_len   : valid lengths, held stable while busy
//   str_addr/str_char  : string buffer read port
//   pat_addr/pat_char  : pattern buffer read port
//   busy, done         : busy outside IDLE; done is a one-cycle result strobe
//   match, match_index : result, held until the next accepted start
// Build option: define SME_CASE_FOLD_EN to compare ASCII letters case-insensitively.
module sme_scan_ctrl #(
  parameter int                CHAR_W    = 8,
  parameter int                STR_DEPTH = 32,
  parameter int                PAT_DEPTH = 8,
  parameter logic [CHAR_W-1:0] SPACE_CH  = 8'h20,
  parameter logic [CHAR_W-1:0] HEAD_CH   = 8'h5E,
  parameter logic [CHAR_W-1:0] TAIL_CH   = 8'h24,
  parameter logic [CHAR_W-1:0] ANY_CH    = 8'h2E
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(STR_DEPTH):0]   str_len,
  input  logic [$clog2(PAT_DEPTH):0]   pat_len,
  output logic [$clog2(STR_DEPTH)-1:0] str_addr,
  input  logic [CHAR_W-1:0]            str_char,
  output logic [$clog2(PAT_DEPTH)-1:0] pat_addr,
  input  logic [CHAR_W-1:0]            pat_char,
  output logic                         busy,
  output logic                         done,
  output logic                         match,
  output logic [$clog2(STR_DEPTH)-1:0] match_index
);

  localparam int SAW = $clog2(STR_DEPTH);
  localparam int SLW = SAW + 1;
  localparam int PAW = $clog2(PAT_DEPTH);
  localparam int PLW = PAW + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    TAIL,
    PRE,
    BODY,
    POST,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [SLW-1:0] s, s_n;
  logic [PLW-1:0] j, j_n;
  logic [PLW-1:0] l_q;
  logic           hh, ht;

  logic           set_match;
  logic           clear_res;
  logic           advance;

  logic           head_hit, tail_hit;
  logic [PLW-1:0] l_tail;
  logic [SLW-1:0] s_inc, s_last, post_pos;

  assign head_hit = (pat_char == HEAD_CH);
  assign tail_hit = (pat_char == TAIL_CH);
  assign l_tail   = pat_len - PLW'(hh) - PLW'(tail_hit);
  assign s_inc    = s + SLW'(1);
  assign s_last   = str_len - SLW'(l_q);
  assign post_pos = s + SLW'(l_q);

  // Body character compare; '.' in the pattern matches anything.
  function automatic logic char_eq(input logic [CHAR_W-1:0] sc,
                                   input logic [CHAR_W-1:0] pc);
    logic [CHAR_W-1:0] a;
    logic [CHAR_W-1:0] b;
    a = sc;
    b = pc;
`ifdef SME_CASE_FOLD_EN
    if (a >= CHAR_W'(8'h61) && a <= CHAR_W'(8'h7A)) a = a - CHAR_W'(8'h20);
    if (b >= CHAR_W'(8'h61) && b <= CHAR_W'(8'h7A)) b = b - CHAR_W'(8'h20);
`endif
    return (pc == ANY_CH) || (a == b);
  endfunction

  // First state visited for a fresh start position. DONE means an
  // empty body with no anchors left to check, so it is an immediate match.
  function automatic state_t route(input logic h, input logic [PLW-1:0] l,
                                   input logic t);
    if (h)              return PRE;
    else if (l != '0)   return BODY;
    else if (t)         return POST;
    else                return DONE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      s           <= '0;
      j           <= '0;
      l_q         <= '0;
      hh          <= 1'b0;
      ht          <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      j     <= j_n;
      if (state == HEAD) hh <= head_hit;
      if (state == TAIL) begin
        ht  <= tail_hit;
        l_q <= l_tail;
      end
      if (clear_res) begin
        match       <= 1'b0;
        match_index <= '0;
      end else if (set_match) begin
        match       <= 1'b1;
        match_index <= s_n[SAW-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    j_n       = j;
    str_addr  = '0;
    pat_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    set_match = 1'b0;
    clear_res = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_n   = HEAD;
          clear_res = 1'b1;
        end
      end

      HEAD: begin
        pat_addr = '0;
        state_n  = TAIL;
      end

      // has_tail is only registered at the end of this cycle, so the body
      // length used here comes from the live tail decode.
      TAIL: begin
        pat_addr = PAW'(pat_len - PLW'(1));
        if (SLW'(l_tail) > str_len) begin
          state_n   = DONE;
          clear_res = 1'b1;
        end else begin
          s_n       = '0;
          j_n       = '0;
          state_n   = route(hh, l_tail, tail_hit);
          set_match = (state_n == DONE);
        end
      end

      PRE: begin
        str_addr = (s == '0) ? '0 : SAW'(s - SLW'(1));
        if ((s == '0) || (str_char == SPACE_CH)) begin
          state_n   = route(1'b0, l_q, ht);
          set_match = (state_n == DONE);
        end else begin
          advance = 1'b1;
        end
      end

      BODY: begin
        str_addr = SAW'(s + SLW'(j));
        pat_addr = PAW'(j + PLW'(hh));
        if (!char_eq(str_char, pat_char)) begin
          advance = 1'b1;
        end else if (j != l_q - PLW'(1)) begin
          j_n = j + PLW'(1);
        end else if (ht) begin
          state_n = POST;
        end else begin
          state_n   = DONE;
          set_match = 1'b1;
        end
      end

      POST: begin
        str_addr = SAW'(post_pos);
        if ((post_pos == str_len) || (str_char == SPACE_CH)) begin
          state_n   = DONE;
          set_match = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    if (advance) begin
      j_n = '0;
      if (s_inc > s_last) begin
        state_n   = DONE;
        clear_res = 1'b1;
      end else begin
        s_n       = s_inc;
        state_n   = route(hh, l_q, ht);
        set_match = (state_n == DONE);
      end
    end
  end

endmodule

// File: tb/tb_sme_scan_ctrl.sv
module tb_sme_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic [4:0] str_addr;
  logic [7:0] str_char;
  logic [2:0] pat_addr;
  logic [7:0] pat_char;
  logic       busy;
  logic       done;
  logic       match;
  logic [4:0] match_index;

  logic [7:0] str_mem [32];
  logic [7:0] pat_mem [8];

  assign str_char = str_mem[str_addr];
  assign pat_char = pat_mem[pat_addr];

  sme_scan_ctrl #(
    .CHAR_W    (8),
    .STR_DEPTH (32),
    .PAT_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .str_len     (str_len),
    .pat_len     (pat_len),
    .str_addr    (str_addr),
    .str_char    (str_char),
    .pat_addr    (pat_addr),
    .pat_char    (pat_char),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .match_index (match_index)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [255:0] str;
    logic [5:0]   slen;
    logic [63:0]  pat;
    logic [3:0]   plen;
    logic         exp_m;
    logic [4:0]   exp_i;
    logic [7:0]   exp_lat;
  } vec_t;

  function automatic vec_t mk(input string s, input string p, input logic m,
                              input int idx, input int lat);
    vec_t v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v.str[8*i +: 8] = s[i];
    for (int i = 0; i < p.len(); i++) v.pat[8*i +: 8] = p[i];
    v.slen    = 6'(s.len());
    v.plen    = 4'(p.len());
    v.exp_m   = m;
    v.exp_i   = 5'(idx);
    v.exp_lat = 8'(lat);
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 32; i++)
      str_mem[i] = (i < int'(v.slen)) ? v.str[8*i +: 8] : 8'($urandom_range(32, 126));
    for (int i = 0; i < 8; i++)
      pat_mem[i] = (i < int'(v.plen)) ? v.pat[8*i +: 8] : 8'($urandom);
    str_len = v.slen;
    pat_len = v.plen;
  endtask

  // lat = number of falling edges after the start-sampling edge until done is seen.
  task automatic run_scan(input bit hold, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Reference: try every start position in order using the anchor/body rules directly.
  function automatic bit ch_eq(input logic [7:0] sc, input logic [7:0] pc);
    logic [7:0] a;
    logic [7:0] b;
    a = sc;
    b = pc;
`ifdef SME_CASE_FOLD_EN
    if (a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    if (b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
`endif
    return (pc == 8'h2E) || (a == b);
  endfunction

  function automatic void ref_scan(input int sl, input int pl, output bit m,
                                   output int idx, output int body_len);
    int hh;
    int ht;
    int l;
    bit ok;
    hh = (pat_mem[0] == 8'h5E) ? 1 : 0;
    ht = (pat_mem[pl-1] == 8'h24 && !(pl == 1 && hh == 1)) ? 1 : 0;
    l  = pl - hh - ht;
    body_len = l;
    m   = 1'b0;
    idx = 0;
    if (l > sl) return;
    for (int s = 0; s <= sl - l; s++) begin
      ok = 1'b1;
      if (hh == 1 && s > 0 && str_mem[s-1] != 8'h20) ok = 1'b0;
      for (int j = 0; j < l; j++)
        if (!ch_eq(str_mem[s+j], pat_mem[j+hh])) ok = 1'b0;
      if (ht == 1 && s + l < sl && str_mem[s+l] != 8'h20) ok = 1'b0;
      if (ok) begin
        m   = 1'b1;
        idx = s;
        return;
      end
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_fail=%0d", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [7:0] alpha [8];

  initial begin
    int  lat;
    bit  got;
    bit  m;
    int  idx;
    int  bl;
    int  sl;
    int  pl;
    int  s0;
    int  seen;
    bit  copy;

    vecs[0]  = mk("ab",       "b",        1'b1, 1, 5);
    vecs[1]  = mk("the cat",  "^cat",     1'b1, 4, 0);
    vecs[2]  = mk("the cat",  "^at",      1'b0, 0, 0);
    vecs[3]  = mk("cats cat", "cat$",     1'b1, 5, 0);
    vecs[4]  = mk("abc",      "a.c",      1'b1, 0, 0);
    vecs[5]  = mk("abc",      "abcd",     1'b0, 0, 3);
    vecs[6]  = mk("x y",      "^$",       1'b0, 0, 0);
    vecs[7]  = mk("x y",      "^",        1'b1, 0, 0);
    vecs[8]  = mk("a$b",      "$b",       1'b1, 1, 0);
    vecs[9]  = mk("ab a",     "a$",       1'b1, 3, 0);
    vecs[10] = mk("xa^b",     "a^",       1'b1, 1, 0);
    vecs[11] = mk("za b",     "a.b",      1'b1, 1, 0);
    vecs[12] = mk("abcdefghijklmnopqrstuvwxyz012xyz", "xyz$", 1'b1, 29, 0);
`ifdef SME_CASE_FOLD_EN
    vecs[13] = mk("xABC",     "abc",      1'b1, 1, 0);
`else
    vecs[13] = mk("xABC",     "abc",      1'b0, 0, 0);
`endif

    alpha = '{8'h61, 8'h62, 8'h41, 8'h20, 8'h2E, 8'h5E, 8'h24, 8'h63};

    reset = 1'b1;
    start = 1'b0;
    load(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_index", 32'(match_index), 32'd0);
    check("rst_str_addr", 32'(str_addr), 32'd0);
    check("rst_pat_addr", 32'(pat_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      load(vecs[i]);
      run_scan(1'b0, lat, got);
      check($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
      if (vecs[i].exp_lat != 0)
        check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_match", i), 32'(match), 32'(vecs[i].exp_m));
      check($sformatf("v%0d_index", i), 32'(match_index), 32'(vecs[i].exp_i));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // Result stays put while idle.
    load(vecs[3]);
    run_scan(1'b0, lat, got);
    repeat (6) @(negedge clk);
    check("hold_match", 32'(match), 32'd1);
    check("hold_index", 32'(match_index), 32'd5);

    // start held high through a whole scan is not re-accepted mid-scan.
    load(vecs[0]);
    run_scan(1'b1, lat, got);
    check("held_start_latency", 32'(lat), 32'd5);
    check("held_start_match", 32'(match), 32'd1);
    check("held_start_index", 32'(match_index), 32'd1);
    repeat (2) @(negedge clk);
    check("held_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of a long scan.
    for (int i = 0; i < 32; i++) str_mem[i] = 8'h61;
    for (int i = 0; i < 7; i++) pat_mem[i] = 8'h61;
    pat_mem[7] = 8'h62;
    str_len = 6'd32;
    pat_len = 4'd8;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (19) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    check("abort_no_early_done", 32'(seen), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_match", 32'(match), 32'd0);
    check("abort_index", 32'(match_index), 32'd0);
    check("abort_str_addr", 32'(str_addr), 32'd0);
    check("abort_pat_addr", 32'(pat_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    load(vecs[1]);
    run_scan(1'b0, lat, got);
    check("post_abort_done", 32'(got), 32'd1);
    check("post_abort_match", 32'(match), 32'd1);
    check("post_abort_index", 32'(match_index), 32'd4);

    // Randomized scans against the reference.
    for (int t = 0; t < 150; t++) begin
      sl = int'($urandom_range(1, 32));
      pl = int'($urandom_range(1, 8));
      for (int i = 0; i < 32; i++) str_mem[i] = alpha[$urandom_range(0, 7)];
      copy = ($urandom_range(0, 1) == 1);
      s0   = int'($urandom_range(0, 31)) % sl;
      for (int i = 0; i < 8; i++) begin
        if (copy && s0 + i < sl) pat_mem[i] = str_mem[s0+i];
        else                     pat_mem[i] = alpha[$urandom_range(0, 7)];
      end
      if ($urandom_range(0, 3) == 0) pat_mem[0] = 8'h5E;
      if ($urandom_range(0, 3) == 0) pat_mem[pl-1] = 8'h24;
      if ($urandom_range(0, 7) == 0) pat_mem[$urandom_range(0, 7)] = 8'h2E;
      str_len = 6'(sl);
      pat_len = 4'(pl);
      ref_scan(sl, pl, m, idx, bl);
      run_scan(1'b0, lat, got);
      check($sformatf("rnd%0d_done_seen", t), 32'(got), 32'd1);
      check($sformatf("rnd%0d_match", t), 32'(match), 32'(m));
      check($sformatf("rnd%0d_index", t), 32'(match_index), 32'(idx));
      if (bl < 0) bl = 0;
      check($sformatf("rnd%0d_lat_bound", t), 32'(lat <= 3 + 33 * (bl + 2)), 32'd1);
      @(negedge clk);
      check($sformatf("rnd%0d_done_pulse", t), 32'(done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
